// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding select encodings,
// wait-state FSM encoding and the forwarding-select helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage ALU result

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_WAIT = 2'b01,
    S_REL  = 2'b10
  } state_t;

  // M has priority over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic reg_write_m,
                                         input logic [4:0] rd_w, input logic reg_write_w);
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copies of Rd/RegWrite/MemRead for the E, M and W stages, advanced in lockstep with
// the real datapath registers so hazard logic can see what is in flight.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   rd_d, reg_write_d,
//   mem_read_d            decode-stage destination info entering E
//   stall_e, flush_e      ID/EX hold and bubble controls
//   stall_m               EX/MEM hold; also bubbles W
//   rd_e, mem_read_e      E-stage shadow fields
//   rd_m, reg_write_m     M-stage shadow fields
//   rd_w, reg_write_w     W-stage shadow fields
module hazard_shadow_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rd_d,
  input  logic       reg_write_d,
  input  logic       mem_read_d,
  input  logic       stall_e,
  input  logic       flush_e,
  input  logic       stall_m,
  output logic [4:0] rd_e,
  output logic       mem_read_e,
  output logic [4:0] rd_m,
  output logic       reg_write_m,
  output logic [4:0] rd_w,
  output logic       reg_write_w
);

  logic reg_write_e;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_e        <= 5'd0;
      reg_write_e <= 1'b0;
      mem_read_e  <= 1'b0;
      rd_m        <= 5'd0;
      reg_write_m <= 1'b0;
      rd_w        <= 5'd0;
      reg_write_w <= 1'b0;
    end else begin
      if (!stall_e) begin
        if (flush_e) begin
          rd_e        <= 5'd0;
          reg_write_e <= 1'b0;
          mem_read_e  <= 1'b0;
        end else begin
          rd_e        <= rd_d;
          reg_write_e <= reg_write_d;
          mem_read_e  <= mem_read_d;
        end
      end
      if (!stall_m) begin
        rd_m        <= rd_e;
        reg_write_m <= reg_write_e;
        rd_w        <= rd_m;
        reg_write_w <= reg_write_m;
      end else begin
        // M is held, so W must not retire the same instruction twice.
        rd_w        <= 5'd0;
        reg_write_w <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing unit for the 5-stage RV32 core: stall/flush/forward controls,
// load-use and control-hazard detection, and a wait-state FSM for peripheral accesses in M.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   Rs1D, Rs2D, RdD               decode-stage register fields
//   RegWriteD, MemReadD           decode-stage write-enable / load flag
//   Rs1E, Rs2E                    execute-stage source registers
//   PCSrcE                        taken branch/jump resolved in E
//   PeriphReqM                    M-stage access targets UART/GPIO
//   StallF/D/E/M, FlushD/E        pipeline register controls
//   ForwardAE, ForwardBE          operand bypass selects
//   RegWriteW                     shadow W-stage write enable
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       RegWriteD,
  input  logic       MemReadD,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic       PCSrcE,
  input  logic       PeriphReqM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       RegWriteW
);

  logic [4:0] rd_e, rd_m, rd_w;
  logic       mem_read_e, reg_write_m;
  logic       lw_stall, mem_stall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_shadow_pipe u_shadow (
    .clk         (clk),
    .reset       (reset),
    .rd_d        (RdD),
    .reg_write_d (RegWriteD),
    .mem_read_d  (MemReadD),
    .stall_e     (StallE),
    .flush_e     (FlushE),
    .stall_m     (StallM),
    .rd_e        (rd_e),
    .mem_read_e  (mem_read_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (RegWriteW)
  );

  assign lw_stall = mem_read_e && (rd_e != 5'd0) && ((rd_e == Rs1D) || (rd_e == Rs2D));

  // Wait-state FSM. S_REL is the cycle the access leaves M; it does not look at PeriphReqM,
  // so the same instruction cannot re-trigger the wait.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (PeriphReqM) begin
          mem_stall = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_REL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_REL:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: peripheral wait > taken branch > load-use. Lower-priority hazards stay pending
  // on the inputs and are acted on once the higher one clears. Outputs are forced low while
  // reset is held so the datapath sees a quiet pipe.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset) begin
      ForwardAE = fwd_sel(Rs1E, rd_m, reg_write_m, rd_w, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, rd_m, reg_write_m, rd_w, RegWriteW);
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (WAIT_CYCLES=2).
module tb_hazard_controller;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E;
  logic       RegWriteD, MemReadD, PCSrcE, PeriphReqM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [5:0] ctl;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] CTL_NONE  = 6'b000000;
  localparam logic [5:0] CTL_MEM   = 6'b111100;
  localparam logic [5:0] CTL_BR    = 6'b000011;
  localparam logic [5:0] CTL_LOAD  = 6'b110001;

  always #5 clk = ~clk;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  hazard_controller #(
    .WAIT_CYCLES (2),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .MemReadD   (MemReadD),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .PCSrcE     (PCSrcE),
    .PeriphReqM (PeriphReqM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .RegWriteW  (RegWriteW)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then step away from it before touching or sampling anything.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rd, input logic rw, input logic mr);
    RdD       = rd;
    RegWriteD = rw;
    MemReadD  = mr;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    PCSrcE = 1'b0; PeriphReqM = 1'b0;
    set_d(5'd0, 1'b0, 1'b0);
  endtask

  task automatic randomize_inputs();
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    Rs1E = 5'($urandom); Rs2E = 5'($urandom);
    RegWriteD = 1'($urandom); MemReadD = 1'($urandom);
    PCSrcE = 1'($urandom); PeriphReqM = 1'($urandom);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #1;

    // 1: reset held while inputs toggle
    for (int i = 0; i < 2; i++) begin
      tick();
      randomize_inputs();
      #1;
      check_eq("rst_outputs", 32'({ctl, ForwardAE, ForwardBE, RegWriteW}), 32'd0);
    end
    check_eq("rst_state", 32'(dut.state_q), 32'(S_RUN));
    check_eq("rst_cnt", 32'(dut.cnt_q), 32'd0);
    clear_inputs();
    reset = 1'b1;
    #1;
    check_eq("rst_release_ctl", 32'(ctl), 32'(CTL_NONE));

    // 2: forwarding
    set_d(5'd5, 1'b1, 1'b0);
    tick();                                   // E=x5
    set_d(5'd0, 1'b0, 1'b0);
    tick();                                   // M=x5
    Rs1E = 5'd5;
    #1;
    check_eq("fwd_a_mem", 32'(ForwardAE), 32'(FWD_MEM));
    check_eq("fwd_b_rf", 32'(ForwardBE), 32'(FWD_RF));
    tick();                                   // W=x5
    check_eq("fwd_a_wb", 32'(ForwardAE), 32'(FWD_WB));
    check_eq("regwrite_w", 32'(RegWriteW), 32'd1);
    Rs1E = 5'd0;
    set_d(5'd0, 1'b1, 1'b0);
    tick();
    set_d(5'd0, 1'b0, 1'b0);
    tick();                                   // M writes x0
    check_eq("fwd_x0", 32'(ForwardAE), 32'(FWD_RF));
    set_d(5'd7, 1'b1, 1'b0);
    tick();
    tick();
    tick();                                   // x7 in both M and W
    Rs2E = 5'd7;
    #1;
    check_eq("fwd_b_prio", 32'(ForwardBE), 32'(FWD_MEM));
    clear_inputs();
    tick(); tick(); tick();

    // 3: load-use bubble
    set_d(5'd6, 1'b1, 1'b1);
    tick();                                   // lw x6 in E
    set_d(5'd0, 1'b0, 1'b0);
    Rs2D = 5'd6;
    #1;
    check_eq("lw_stall", 32'(ctl), 32'(CTL_LOAD));
    tick();
    check_eq("lw_one_bubble", 32'(ctl), 32'(CTL_NONE));
    Rs2D = 5'd0;
    tick();                                   // dependent now in E, lw in W
    Rs2E = 5'd6;
    #1;
    check_eq("lw_fwd_b", 32'(ForwardBE), 32'(FWD_WB));
    Rs2E = 5'd0;

    // 4: branch beats load-use
    set_d(5'd9, 1'b1, 1'b1);
    tick();
    set_d(5'd0, 1'b0, 1'b0);
    Rs1D = 5'd9;
    PCSrcE = 1'b1;
    #1;
    check_eq("br_over_lw", 32'(ctl), 32'(CTL_BR));
    PCSrcE = 1'b0;
    #1;
    check_eq("lw_alone", 32'(ctl), 32'(CTL_LOAD));
    Rs1D = 5'd0;
    tick();

    // 5: peripheral wait states
    set_d(5'd4, 1'b1, 1'b0);
    tick();
    set_d(5'd8, 1'b1, 1'b0);
    tick();
    set_d(5'd2, 1'b1, 1'b0);
    tick();                                   // E=x2 M=x8 W=x4
    set_d(5'd0, 1'b0, 1'b0);
    PeriphReqM = 1'b1;
    #1;
    check_eq("w_pre_stall", 32'(RegWriteW), 32'd1);
    check_eq("periph1_c1", 32'(ctl), 32'(CTL_MEM));
    tick();
    check_eq("periph1_c2", 32'(ctl), 32'(CTL_MEM));
    check_eq("w_bubble", 32'(RegWriteW), 32'd0);
    check_eq("periph1_state", 32'(dut.state_q), 32'(S_WAIT));
    Rs1E = 5'd8;
    #1;
    check_eq("fwd_m_held", 32'(ForwardAE), 32'(FWD_MEM));
    Rs1E = 5'd0;
    tick();
    check_eq("periph1_c3", 32'(ctl), 32'(CTL_MEM));
    check_eq("w_bubble_c3", 32'(RegWriteW), 32'd0);
    tick();
    check_eq("periph1_rel", 32'(ctl), 32'(CTL_NONE));
    tick();                                   // next access already in M
    check_eq("w_after_rel", 32'(RegWriteW), 32'd1);
    check_eq("periph2_c1", 32'(ctl), 32'(CTL_MEM));
    tick();
    PCSrcE = 1'b1;
    #1;
    check_eq("periph2_c2_br_held", 32'(ctl), 32'(CTL_MEM));
    PCSrcE = 1'b0;
    tick();
    check_eq("periph2_c3", 32'(ctl), 32'(CTL_MEM));
    tick();
    check_eq("periph2_rel", 32'(ctl), 32'(CTL_NONE));
    PeriphReqM = 1'b0;
    tick();
    check_eq("periph_idle", 32'(ctl), 32'(CTL_NONE));

    // 6: reset during S_WAIT
    PeriphReqM = 1'b1;
    tick();
    check_eq("mid_state", 32'(dut.state_q), 32'(S_WAIT));
    check_eq("mid_cnt", 32'(dut.cnt_q), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    PeriphReqM = 1'b0;
    #1;
    check_eq("abort_state", 32'(dut.state_q), 32'(S_RUN));
    check_eq("abort_cnt", 32'(dut.cnt_q), 32'd0);
    check_eq("abort_ctl", 32'(ctl), 32'(CTL_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
